// File: rtl/ballot_unit_if.sv
// ballot_unit_if: groups the ballot control and vote-strobe signals.
//   arm     : officer ballot-release request
//   key     : raw candidate keys, key[0] = candidate 1
//   en      : one-cycle vote strobe to the vote counter
//   button  : candidate code, valid while en = 1
//   ready   : ballot armed and awaiting a key
//   done    : one-cycle pulse coincident with en
//   multi   : more than one debounced key high while armed
//   timeout : one-cycle pulse when an armed ballot expires
// Modports: master drives arm/key (officer + keypad side),
//           slave is the ballot_unit side.
interface ballot_unit_if;
    logic       arm;
    logic [3:0] key;
    logic       en;
    logic [3:0] button;
    logic       ready;
    logic       done;
    logic       multi;
    logic       timeout;

    modport master (
        output arm, key,
        input  en, button, ready, done, multi, timeout
    );

    modport slave (
        input  arm, key,
        output en, button, ready, done, multi, timeout
    );
endinterface

// File: rtl/ballot_unit.sv
// ballot_unit: accepts one keyed vote per officer arm.
// Raw keys are synchronised (2 FF) and debounced per bit; a single
// debounced key while ARMED produces a one-cycle en/done strobe with the
// candidate code on button. All outputs are registered.
// Ports:
//   clk : clock
//   rst : asynchronous, active-high reset
//   bus : ballot_unit_if.slave (arm, key in; en, button, ready, done,
//         multi, timeout out)
// Parameters:
//   DEBOUNCE_CYCLES : stable samples needed to accept a key level (2..255)
//   TIMEOUT_CYCLES  : cycles allowed in ARMED before withdrawal (2..65535)
// Build option:
//   BALLOT_TIMEOUT_EN : when defined, an armed ballot expires after
//                       TIMEOUT_CYCLES cycles; otherwise timeout is tied 0.
module ballot_unit #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input logic         clk,
    input logic         rst,
    ballot_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAST    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] deb;
    logic [7:0] deb_cnt [4];

    state_t     state;
    state_t     state_next;
    logic       en_q, en_next;
    logic [3:0] button_q, button_next;
    logic       ready_q, done_q, multi_q;
    logic [2:0] n_high;
    logic [3:0] code;
    logic       single;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.key;
            sync2 <= sync1;
        end
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive
    // mismatching samples; any matching sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb <= '0;
            for (int unsigned i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        n_high = 3'(deb[0]) + 3'(deb[1]) + 3'(deb[2]) + 3'(deb[3]);
        single = (n_high == 3'd1);
        case (deb)
            4'b0001: code = 4'd1;
            4'b0010: code = 4'd2;
            4'b0100: code = 4'd3;
            4'b1000: code = 4'd4;
            default: code = 4'd0;
        endcase
    end

`ifdef BALLOT_TIMEOUT_EN
    localparam logic [15:0] TMR_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmr;
    logic        timeout_q;
    logic        timeout_next;

    // Cleared whenever not ARMED, so it reads 0 on the first ARMED cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                tmr <= '0;
        else if (state != ARMED) tmr <= '0;
        else                    tmr <= tmr + 16'd1;
    end
`endif

    always_comb begin
        state_next  = state;
        en_next     = 1'b0;
        button_next = '0;
`ifdef BALLOT_TIMEOUT_EN
        timeout_next = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.arm && (deb == '0)) state_next = ARMED;
            end
            ARMED: begin
                // A single-key detection takes priority over expiry.
                if (single) begin
                    state_next  = CAST;
                    en_next     = 1'b1;
                    button_next = code;
                end
`ifdef BALLOT_TIMEOUT_EN
                else if (tmr == TMR_LAST) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                end
`endif
            end
            CAST: begin
                state_next = RELEASE;
            end
            RELEASE: begin
                if (deb == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they line up with the
    // registered state rather than lagging it by a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            en_q     <= 1'b0;
            button_q <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            multi_q  <= 1'b0;
`ifdef BALLOT_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            en_q     <= en_next;
            button_q <= button_next;
            ready_q  <= (state_next == ARMED);
            done_q   <= en_next;
            multi_q  <= (state_next == ARMED) && (n_high > 3'd1);
`ifdef BALLOT_TIMEOUT_EN
            timeout_q <= timeout_next;
`endif
        end
    end

    assign bus.en     = en_q;
    assign bus.button = button_q;
    assign bus.ready  = ready_q;
    assign bus.done   = done_q;
    assign bus.multi  = multi_q;
`ifdef BALLOT_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ballot_unit.sv
// tb_ballot_unit: randomized self-checking bench for ballot_unit with
// DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=32. Expected votes, latencies and
// ballot lifetimes come from a transaction-level view of the ballot rules.
module tb_ballot_unit;

    localparam int D   = 4;
    localparam int T   = 32;
    localparam int LAT = D + 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ballot_unit_if bus ();

    ballot_unit #(
        .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int en_seen  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: a ballot is cast only for exactly one key; code = index + 1.
    function automatic logic [3:0] vote_code(input logic [3:0] keys);
        int         hits = 0;
        logic [3:0] c    = '0;
        for (int i = 0; i < 4; i++) begin
            if (keys[i]) begin
                hits++;
                c = 4'(i + 1);
            end
        end
        return (hits == 1) ? c : 4'd0;
    endfunction

    // Continuous invariants: done tracks en, button idles at zero.
    always @(negedge clk) begin
        if (bus.en === 1'b1) en_seen++;
        check("done_eq_en", 32'(bus.done), 32'(bus.en));
        if (bus.en !== 1'b1) check("button_idle", 32'(bus.button), 32'd0);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic arm_pulse();
        @(negedge clk);
        bus.arm = 1'b1;
        @(negedge clk);
        bus.arm = 1'b0;
    endtask

    task automatic wait_en(input int budget, output int cyc, output logic [3:0] code);
        cyc  = -1;
        code = '0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (bus.en === 1'b1) begin
                cyc  = i;
                code = bus.button;
                break;
            end
        end
    endtask

    task automatic settle();
        bus.key = '0;
        step(LAT + 6);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        int         cyc;
        int         base;
        int         k;
        int         k2;
        int         w;
        int         n;
        logic [3:0] code;
        logic [3:0] keys;

        rst     = 1'b0;
        bus.arm = 1'b0;
        bus.key = '0;
        #1 rst = 1'b1;
        step(2);
        check("rst_en",      32'(bus.en),      32'd0);
        check("rst_button",  32'(bus.button),  32'd0);
        check("rst_ready",   32'(bus.ready),   32'd0);
        check("rst_done",    32'(bus.done),    32'd0);
        check("rst_multi",   32'(bus.multi),   32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);
        rst = 1'b0;
        step(2);
        check("idle_ready", 32'(bus.ready), 32'd0);

        // Clean single presses: exact latency and candidate code.
        for (int it = 0; it < 4; it++) begin
            k    = $urandom_range(0, 3);
            base = en_seen;
            arm_pulse();
            check("s1_arm_ready", 32'(bus.ready), 32'd1);
            step($urandom_range(0, 4));
            keys    = 4'(1 << k);
            bus.key = keys;
            wait_en(LAT + 4, cyc, code);
            check("s1_latency", 32'(cyc), 32'(LAT));
            check("s1_button",  32'(code), 32'(vote_code(keys)));
            check("s1_done",    32'(bus.done), 32'd1);
            step(1);
            check("s1_ready_low", 32'(bus.ready), 32'd0);
            step(10);
            check("s1_one_vote", 32'(en_seen - base), 32'd1);
            settle();
        end

        // Two keys: held in ARMED with multi, then the remaining key wins.
        k  = $urandom_range(0, 3);
        k2 = (k + $urandom_range(1, 3)) % 4;
        base = en_seen;
        arm_pulse();
        bus.key = 4'(1 << k) | 4'(1 << k2);
        step(20);
        check("s2_multi",   32'(bus.multi), 32'd1);
        check("s2_ready",   32'(bus.ready), 32'd1);
        check("s2_no_vote", 32'(en_seen - base), 32'd0);
        keys    = 4'(1 << k2);
        bus.key = keys;
        wait_en(20, cyc, code);
        check("s2_cast",   32'(cyc > 0), 32'd1);
        check("s2_button", 32'(code), 32'(vote_code(keys)));
        settle();

        // Glitch shorter than the debounce window is rejected.
        base = en_seen;
        arm_pulse();
        step(2);
        w = $urandom_range(1, D - 1);
        bus.key = 4'b0010;
        step(w);
        bus.key = '0;
        step(10);
        check("s3_glitch_no_vote", 32'(en_seen - base), 32'd0);
        check("s3_still_ready",    32'(bus.ready), 32'd1);
        keys    = 4'b0010;
        bus.key = keys;
        wait_en(LAT + 4, cyc, code);
        check("s3_latency", 32'(cyc), 32'(LAT));
        check("s3_button",  32'(code), 32'(vote_code(keys)));
        settle();

        // Unanswered ballot.
        base = en_seen;
        arm_pulse();
        n = 0;
        while (bus.ready === 1'b1 && n < 100) begin
            n++;
            step(1);
        end
`ifdef BALLOT_TIMEOUT_EN
        check("s4_armed_cycles",   32'(n), 32'(T));
        check("s4_timeout_pulse",  32'(bus.timeout), 32'd1);
        step(1);
        check("s4_timeout_width",  32'(bus.timeout), 32'd0);
        check("s4_ready_low",      32'(bus.ready), 32'd0);
        bus.key = 4'(1 << $urandom_range(0, 3));
        step(LAT + 10);
        check("s4_no_vote_after",  32'(en_seen - base), 32'd0);
`else
        check("s4_armed_forever",  32'(n), 32'd100);
        check("s4_timeout_tied",   32'(bus.timeout), 32'd0);
        keys    = 4'(1 << $urandom_range(0, 3));
        bus.key = keys;
        wait_en(LAT + 4, cyc, code);
        check("s4_button",         32'(code), 32'(vote_code(keys)));
`endif
        settle();

        // Arm during RELEASE is ignored; a fresh arm after release works.
        base = en_seen;
        arm_pulse();
        keys    = 4'(1 << $urandom_range(0, 3));
        bus.key = keys;
        wait_en(LAT + 4, cyc, code);
        check("s5_button", 32'(code), 32'(vote_code(keys)));
        step(2);
        arm_pulse();
        step(1);
        arm_pulse();
        step(20);
        check("s5_single_vote", 32'(en_seen - base), 32'd1);
        check("s5_ready_low",   32'(bus.ready), 32'd0);
        bus.key = '0;
        step(LAT + 6);
        arm_pulse();
        check("s5_rearm_ready", 32'(bus.ready), 32'd1);

        // Reset during CAST kills the vote immediately.
        bus.key = 4'(1 << $urandom_range(0, 3));
        step(LAT - 1);
        step(1);
        check("s6_in_cast", 32'(bus.en), 32'd1);
        rst = 1'b1;
        #1;
        check("s6_rst_en",     32'(bus.en),     32'd0);
        check("s6_rst_button", 32'(bus.button), 32'd0);
        check("s6_rst_ready",  32'(bus.ready),  32'd0);
        check("s6_rst_done",   32'(bus.done),   32'd0);
        step(3);
        rst  = 1'b0;
        base = en_seen;
        step(20);
        arm_pulse();
        check("s6_arm_ignored_key_high", 32'(bus.ready), 32'd0);
        step(10);
        check("s6_no_vote_after_rst", 32'(en_seen - base), 32'd0);
        bus.key = '0;
        step(LAT + 6);
        arm_pulse();
        keys    = 4'(1 << $urandom_range(0, 3));
        bus.key = keys;
        wait_en(LAT + 4, cyc, code);
        check("s6_new_latency", 32'(cyc), 32'(LAT));
        check("s6_new_button",  32'(code), 32'(vote_code(keys)));
        settle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ballot_unit.md
BALLOT_UNIT -- requirements
Module: ballot_unit

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the number of consecutive stable synchronized samples before a key level is accepted (range 2..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum number of cycles in ARMED before the ballot is withdrawn (range 2..65535).
REQ-003 SHALL have port clk, input, 1, the clock; reset rst, asynchronous, active-high.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port arm, input, 1, synchronous officer ballot-release request, sampled every clk.
REQ-006 SHALL have port key, input, 4, raw asynchronous active-high candidate keys; key[0] is candidate 1 and key[3] is candidate 4.
REQ-007 SHALL have port en, output, 1, one-cycle vote strobe to the vote counter.
REQ-008 SHALL have port button, output, 4, candidate code, valid only while en=1.
REQ-009 SHALL have port ready, output, 1, high while a ballot is armed and awaiting a key.
REQ-010 SHALL have port done, output, 1, one-cycle pulse coincident with en.
REQ-011 SHALL have port multi, output, 1, high while in ARMED with more than one debounced key high.
REQ-012 SHALL have port timeout, output, 1, one-cycle pulse when an armed ballot expires.

Function
REQ-013 SHALL pass each key bit through a 2-FF synchronizer, then a per-key debouncer; a debounced bit takes the synchronized value after DEBOUNCE_CYCLES consecutive cycles of mismatch, and its counter SHALL clear on any match.
REQ-014 SHALL implement the states IDLE, ARMED, CAST and RELEASE, encoded as 2 bits.
REQ-015 SHALL move from IDLE to ARMED on arm=1 only when all debounced keys are 0; an arm in IDLE with any debounced key high SHALL be ignored.
REQ-016 SHALL ignore arm in ARMED, CAST and RELEASE; it SHALL NOT restart the timeout.
REQ-017 SHALL move from ARMED to CAST in the cycle after exactly one debounced key is high.
REQ-018 SHALL hold ARMED with multi=1 while two or more debounced keys are high, casting no vote; if the extra keys are released while one remains high, the vote SHALL be cast for the remaining key.
REQ-019 SHALL be in CAST for exactly one cycle, with en=1, done=1, and button = 4'b0001, 4'b0010, 4'b0011 or 4'b0100 for candidate 1, 2, 3 or 4 respectively; the next state SHALL be RELEASE.
REQ-020 SHALL hold en=0 and button=4'b0000 in all states other than CAST.
REQ-021 SHALL move from RELEASE to IDLE once all debounced keys are 0; keys held in RELEASE SHALL NOT produce further votes.
REQ-022 SHALL drive ready=1 exactly while the state is ARMED.
REQ-023 SHALL register all outputs; raw key to en latency SHALL be DEBOUNCE_CYCLES+3 clk edges for a clean single press while ARMED.
REQ-024 SHALL produce at most one en pulse per accepted arm.

Reset
REQ-025 SHALL, on rst=1, immediately force state=IDLE, en=0, button=0, ready=0, done=0, multi=0 and timeout=0, and clear the synchronizers, debounced levels and all counters, including during CAST.
REQ-026 SHALL require a new arm after rst deasserts; a ballot armed before reset SHALL be lost, with no vote emitted.

Configuration
REQ-027 SHALL, with BALLOT_TIMEOUT_EN defined, count cycles in ARMED (starting at 0 on entry) and, after TIMEOUT_CYCLES cycles without a transition to CAST, move to IDLE with timeout=1 for one cycle; a single-key detection in the expiry cycle SHALL win over the timeout.
REQ-028 SHALL, without BALLOT_TIMEOUT_EN, omit the timeout counter, remain in ARMED indefinitely, and tie timeout to 0.

Verification (bench: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=32, BALLOT_TIMEOUT_EN defined)
REQ-029 SHALL cover: arm pulse, then key=4'b0100 held -> one en pulse with button=4'b0011 exactly 7 edges after the key edge; done=1 in the same cycle; ready falls.
REQ-030 SHALL cover: armed, key=4'b0101 held 20 cycles -> multi=1 and no en; then key=4'b0001 -> one en with button=4'b0001.
REQ-031 SHALL cover: armed, a 2-cycle glitch on key[1] -> no en; a later clean press on key[1] -> en with button=4'b0010.
REQ-032 SHALL cover: arm with no keys for 32 cycles -> timeout pulse, return to IDLE; a key press afterwards -> no en.
REQ-033 SHALL cover: a vote cast, key held, arm pulsed twice during RELEASE -> no second en; release the key, then arm -> ready=1.
REQ-034 SHALL cover: rst asserted while in CAST -> en=0 and button=0 immediately; no en after rst deasserts until a new arm and press.
